// File: rtl/filter_fwd.sv
// rtl/filter_fwd.sv - frame-aware forwarding stage from rx FIFOs to tx FIFOs
//
// Each of NCH channels pops words from a first-word-fall-through receive FIFO
// and pushes them into a transmit FIFO. Idle words are discarded. Frames are
// admitted or dropped whole, and over-length frames are truncated. Every
// forwarded frame is closed with a {1'b0, 0} terminator word.
//
// Ports (channel i occupies slice i of each flattened bus):
//   sys_clk    - single clock
//   sys_rst_n  - synchronous active-low reset
//   ch_en      - per-channel enable, sampled at frame start only
//   stat_clr   - pulse that zeroes all statistics counters
//   rd_en      - pop strobe to each receive FIFO
//   rd_data    - head word of each receive FIFO (bit DATA_W = in-frame flag)
//   rd_empty   - receive FIFO empty
//   wr_en      - push strobe to each transmit FIFO
//   wr_data    - word pushed to each transmit FIFO
//   wr_full    - transmit FIFO full
//   fwd_cnt    - frames forwarded complete (saturating)
//   drop_cnt   - frames dropped whole (saturating)
//   trunc_cnt  - frames truncated at MAX_LEN (saturating)
module filter_fwd #(
   parameter int DATA_W  = 8,
   parameter int NCH     = 2,
   parameter int MAX_LEN = 1518,
   parameter int CNT_W   = 16
) (
   input  logic                      sys_clk,
   input  logic                      sys_rst_n,
   input  logic [NCH-1:0]            ch_en,
   input  logic                      stat_clr,
   output logic [NCH-1:0]            rd_en,
   input  logic [NCH*(DATA_W+1)-1:0] rd_data,
   input  logic [NCH-1:0]            rd_empty,
   output logic [NCH-1:0]            wr_en,
   output logic [NCH*(DATA_W+1)-1:0] wr_data,
   input  logic [NCH-1:0]            wr_full,
   output logic [NCH*CNT_W-1:0]      fwd_cnt,
   output logic [NCH*CNT_W-1:0]      drop_cnt,
   output logic [NCH*CNT_W-1:0]      trunc_cnt
);

   localparam int WW    = DATA_W + 1;
   localparam int LEN_W = $clog2(MAX_LEN + 1);
   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      state_t            state_q, state_d;
      logic [LEN_W-1:0]  len_q, len_d;
      logic [CNT_W-1:0]  fwd_q, drop_q, trunc_q;
      logic              fwd_inc, drop_inc, trunc_inc;
      logic              pop, push;
      logic [WW-1:0]     push_word;
      logic [WW-1:0]     head;
      logic              flag;
      logic              avail;
      logic              full;

      assign head  = rd_data[i*WW +: WW];
      assign flag  = head[DATA_W];
      assign avail = ~rd_empty[i];
      assign full  = wr_full[i];

      always_comb begin
         state_d   = state_q;
         len_d     = len_q;
         pop       = 1'b0;
         push      = 1'b0;
         push_word = '0;
         fwd_inc   = 1'b0;
         drop_inc  = 1'b0;
         trunc_inc = 1'b0;
         // Every decision needs a head word; an empty FIFO simply holds state,
         // so a gap inside a frame never ends it.
         if (avail) begin
            unique case (state_q)
               ST_IDLE: begin
                  if (!flag) begin
                     pop = 1'b1;
                  end else if (ch_en[i]) begin
                     if (!full) begin
                        pop       = 1'b1;
                        push      = 1'b1;
                        push_word = head;
                        len_d     = LEN_W'(1);
                        state_d   = ST_FWD;
                     end
                  end else begin
                     pop      = 1'b1;
                     drop_inc = 1'b1;
                     state_d  = ST_DROP;
                  end
               end
               ST_FWD: begin
                  if (!full) begin
                     if (!flag) begin
                        // Separator consumed; terminator written in its place.
                        pop     = 1'b1;
                        push    = 1'b1;
                        fwd_inc = 1'b1;
                        len_d   = '0;
                        state_d = ST_IDLE;
                     end else if (len_q < MAX_LEN_L) begin
                        pop       = 1'b1;
                        push      = 1'b1;
                        push_word = head;
                        len_d     = len_q + LEN_W'(1);
                     end else begin
                        // Over-length: close the frame without consuming the
                        // head; DROP discards it and the rest of the frame.
                        push      = 1'b1;
                        trunc_inc = 1'b1;
                        len_d     = '0;
                        state_d   = ST_DROP;
                     end
                  end
               end
               ST_DROP: begin
                  pop = 1'b1;
                  if (!flag) begin
                     state_d = ST_IDLE;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
               end
            endcase
         end
      end

      // Strobes and data are forced low while reset is held.
      assign rd_en[i]            = pop & sys_rst_n;
      assign wr_en[i]            = push & sys_rst_n;
      assign wr_data[i*WW +: WW] = (push & sys_rst_n) ? push_word : '0;

      always_ff @(posedge sys_clk) begin
         if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
         end else begin
            state_q <= state_d;
            len_q   <= len_d;
         end
      end

      // Clear wins over a coincident increment; counters stick at all-ones.
      always_ff @(posedge sys_clk) begin
         if (!sys_rst_n || stat_clr) begin
            fwd_q   <= '0;
            drop_q  <= '0;
            trunc_q <= '0;
         end else begin
            if (fwd_inc && !(&fwd_q)) begin
               fwd_q <= fwd_q + CNT_W'(1);
            end
            if (drop_inc && !(&drop_q)) begin
               drop_q <= drop_q + CNT_W'(1);
            end
            if (trunc_inc && !(&trunc_q)) begin
               trunc_q <= trunc_q + CNT_W'(1);
            end
         end
      end

      assign fwd_cnt[i*CNT_W +: CNT_W]   = fwd_q;
      assign drop_cnt[i*CNT_W +: CNT_W]  = drop_q;
      assign trunc_cnt[i*CNT_W +: CNT_W] = trunc_q;
   end

endmodule

// File: tb/tb_filter_fwd.sv
// tb/tb_filter_fwd.sv - self-checking bench for filter_fwd
module tb_filter_fwd;

   localparam int NCH  = 2;
   localparam int MAXL = 4;
   localparam int CW   = 2;
   localparam int WW   = 9;
   localparam int SAT  = 3;

   logic             sys_clk = 1'b0;
   logic             sys_rst_n;
   logic [NCH-1:0]   ch_en;
   logic             stat_clr;
   logic [NCH-1:0]   rd_en;
   logic [NCH*WW-1:0] rd_data;
   logic [NCH-1:0]   rd_empty;
   logic [NCH-1:0]   wr_en;
   logic [NCH*WW-1:0] wr_data;
   logic [NCH-1:0]   wr_full;
   logic [NCH*CW-1:0] fwd_cnt;
   logic [NCH*CW-1:0] drop_cnt;
   logic [NCH*CW-1:0] trunc_cnt;

   filter_fwd #(
      .DATA_W(8), .NCH(NCH), .MAX_LEN(MAXL), .CNT_W(CW)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ch_en(ch_en),
      .stat_clr(stat_clr), .rd_en(rd_en), .rd_data(rd_data),
      .rd_empty(rd_empty), .wr_en(wr_en), .wr_data(wr_data),
      .wr_full(wr_full), .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt),
      .trunc_cnt(trunc_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [8:0]  rx_mem [NCH][0:4095];
   int          rx_rd [NCH];
   int          rx_wr [NCH];
   bit          gap_v [NCH];
   bit          full_v [NCH];
   logic [8:0]  got_q [NCH][$];
   logic [8:0]  exp_q [NCH][$];
   int          got_cyc[$];
   int          cyc = 0;
   int          m_fwd [NCH];
   int          m_drop [NCH];
   int          m_trunc [NCH];
   logic [NCH-1:0]    s_rd_en, s_wr_en;
   logic [NCH*WW-1:0] s_wr_data;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int sat_inc(input int x);
      return (x >= SAT) ? SAT : x + 1;
   endfunction

   task automatic add_word(input int ch, input logic [8:0] w);
      rx_mem[ch][rx_wr[ch]] = w;
      rx_wr[ch]++;
   endtask

   task automatic clear_model();
      for (int c = 0; c < NCH; c++) begin
         m_fwd[c] = 0; m_drop[c] = 0; m_trunc[c] = 0;
      end
   endtask

   // Expected tx stream and counters from the words loaded since 'from':
   // split into frames, then admit/drop/truncate each one as a whole.
   task automatic model(input int ch, input bit en, input int from);
      int len = 0;
      int start = from;
      for (int k = from; k < rx_wr[ch]; k++) begin
         if (rx_mem[ch][k][8]) begin
            if (len == 0) start = k;
            len++;
         end else if (len > 0) begin
            if (!en) begin
               m_drop[ch] = sat_inc(m_drop[ch]);
            end else begin
               for (int j = 0; j < ((len < MAXL) ? len : MAXL); j++)
                  exp_q[ch].push_back(rx_mem[ch][start + j]);
               exp_q[ch].push_back(9'h000);
               if (len > MAXL) m_trunc[ch] = sat_inc(m_trunc[ch]);
               else            m_fwd[ch]   = sat_inc(m_fwd[ch]);
            end
            len = 0;
         end
      end
   endtask

   task automatic apply_inputs();
      for (int c = 0; c < NCH; c++) begin
         rd_empty[c] = gap_v[c] || (rx_rd[c] >= rx_wr[c]);
         if (rd_empty[c]) rd_data[c*WW +: WW] = 9'($urandom);
         else             rd_data[c*WW +: WW] = rx_mem[c][rx_rd[c]];
         wr_full[c] = full_v[c];
      end
   endtask

   task automatic step();
      bit popped [NCH];
      apply_inputs();
      #4;
      s_rd_en   = rd_en;
      s_wr_en   = wr_en;
      s_wr_data = wr_data;
      for (int c = 0; c < NCH; c++) begin
         check_eq("rd_en_while_empty", 32'(rd_en[c] & rd_empty[c]), 0);
         check_eq("wr_en_while_full", 32'(wr_en[c] & wr_full[c]), 0);
         if (!wr_en[c]) check_eq("wr_data_idle", 32'(wr_data[c*WW +: WW]), 0);
         popped[c] = rd_en[c];
         if (wr_en[c]) begin
            got_q[c].push_back(wr_data[c*WW +: WW]);
            if (c == 0) got_cyc.push_back(cyc);
         end
      end
      @(posedge sys_clk);
      #1;
      for (int c = 0; c < NCH; c++) if (popped[c]) rx_rd[c]++;
      cyc++;
   endtask

   task automatic drain(input bit rnd);
      int n = 0;
      while ((rx_rd[0] < rx_wr[0] || rx_rd[1] < rx_wr[1]) && n < 3000) begin
         for (int c = 0; c < NCH; c++) begin
            gap_v[c]  = rnd && ($urandom_range(3) == 0);
            full_v[c] = rnd && ($urandom_range(3) == 0);
         end
         step();
         n++;
      end
      check_eq("drain_timeout", 32'(n < 3000), 1);
      for (int c = 0; c < NCH; c++) begin
         gap_v[c] = 1'b0; full_v[c] = 1'b0;
      end
      step();
   endtask

   task automatic compare(input string tag);
      for (int c = 0; c < NCH; c++) begin
         check_eq({tag, "_count"}, got_q[c].size(), exp_q[c].size());
         for (int k = 0; k < got_q[c].size() && k < exp_q[c].size(); k++)
            check_eq({tag, "_word"}, 32'(got_q[c][k]), 32'(exp_q[c][k]));
         check_eq({tag, "_fwd_cnt"},   32'(fwd_cnt[c*CW +: CW]),   m_fwd[c]);
         check_eq({tag, "_drop_cnt"},  32'(drop_cnt[c*CW +: CW]),  m_drop[c]);
         check_eq({tag, "_trunc_cnt"}, 32'(trunc_cnt[c*CW +: CW]), m_trunc[c]);
         got_q[c].delete();
         exp_q[c].delete();
      end
   endtask

   task automatic pulse_clr();
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      clear_model();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      int idx;
      sys_rst_n = 1'b0;
      ch_en     = '1;
      stat_clr  = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         rx_rd[c] = 0; rx_wr[c] = 0; gap_v[c] = 0; full_v[c] = 0;
      end
      clear_model();

      // Reset state, with a frame start already waiting at the head.
      add_word(0, 9'h000); add_word(0, 9'h1A1); add_word(0, 9'h1A2);
      add_word(0, 9'h1A3); add_word(0, 9'h000);
      model(0, 1'b1, 0);
      rx_rd[0] = 1;
      step();
      step();
      check_eq("rst_rd_en", 32'(s_rd_en), 0);
      check_eq("rst_wr_en", 32'(s_wr_en), 0);
      check_eq("rst_wr_data", 32'(s_wr_data), 0);
      check_eq("rst_counters", 32'({fwd_cnt, drop_cnt, trunc_cnt}), 0);
      rx_rd[0] = 0;

      // Basic forward: four pushes on consecutive cycles.
      sys_rst_n = 1'b1;
      got_cyc.delete();
      drain(1'b0);
      check_eq("basic_push_count", got_cyc.size(), 4);
      if (got_cyc.size() == 4)
         for (int k = 1; k < 4; k++)
            check_eq("basic_consecutive", got_cyc[k] - got_cyc[0], k);
      check_eq("basic_fwd_one", 32'(fwd_cnt[1:0]), 1);
      compare("basic");

      // Backpressure: five stalled cycles after B1.
      st = rx_wr[0];
      add_word(0, 9'h000); add_word(0, 9'h1B1); add_word(0, 9'h1B2);
      add_word(0, 9'h1B3); add_word(0, 9'h000);
      model(0, 1'b1, st);
      step();
      step();
      check_eq("bp_first_word", 32'(s_wr_data[8:0]), 32'h1B1);
      full_v[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check_eq("bp_stall_rd_en", 32'(s_rd_en[0]), 0);
      end
      full_v[0] = 1'b0;
      step();
      check_eq("bp_resume_wr_en", 32'(s_wr_en[0]), 1);
      check_eq("bp_resume_word", 32'(s_wr_data[8:0]), 32'h1B2);
      drain(1'b0);
      compare("bp");

      // Disabled channel, re-enabled mid-frame: the frame is still dropped.
      ch_en[1] = 1'b0;
      st = rx_wr[1];
      for (int k = 1; k <= 4; k++) add_word(1, 9'h1C0 + 9'(k));
      add_word(1, 9'h000);
      model(1, 1'b0, st);
      step();
      step();
      ch_en[1] = 1'b1;
      drain(1'b0);
      check_eq("dis_popped", rx_rd[1] - st, 5);
      compare("dis");

      // Truncation of a 7-word frame at MAX_LEN = 4.
      pulse_clr();
      st = rx_wr[0];
      add_word(0, 9'h000);
      for (int k = 1; k <= 7; k++) add_word(0, 9'h1D0 + 9'(k));
      add_word(0, 9'h000);
      model(0, 1'b1, st);
      drain(1'b0);
      check_eq("trunc_cnt_one", 32'(trunc_cnt[1:0]), 1);
      check_eq("trunc_fwd_zero", 32'(fwd_cnt[1:0]), 0);
      compare("trunc");

      // Counter saturation, then clear coinciding with an increment.
      pulse_clr();
      st = rx_wr[0];
      for (int k = 0; k < 5; k++) begin
         add_word(0, 9'h1E0 + 9'(k)); add_word(0, 9'h000);
      end
      model(0, 1'b1, st);
      drain(1'b1);
      check_eq("sat_fwd", 32'(fwd_cnt[1:0]), SAT);
      compare("sat");
      add_word(0, 9'h1F6); add_word(0, 9'h000);
      exp_q[0].push_back(9'h1F6); exp_q[0].push_back(9'h000);
      step();
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      clear_model();
      step();
      check_eq("clr_wins", 32'(fwd_cnt[1:0]), 0);
      compare("clr");

      // Reset after two words of a four-word frame.
      st = rx_wr[0];
      add_word(0, 9'h000); add_word(0, 9'h191); add_word(0, 9'h192);
      add_word(0, 9'h193); add_word(0, 9'h194); add_word(0, 9'h000);
      idx = st + 3;
      exp_q[0].push_back(9'h191); exp_q[0].push_back(9'h192);
      step(); step(); step();
      sys_rst_n = 1'b0;
      step();
      check_eq("midrst_rd_en", 32'(s_rd_en), 0);
      check_eq("midrst_wr_en", 32'(s_wr_en), 0);
      check_eq("midrst_wr_data", 32'(s_wr_data), 0);
      check_eq("midrst_counters", 32'({fwd_cnt, drop_cnt, trunc_cnt}), 0);
      step();
      sys_rst_n = 1'b1;
      clear_model();
      check_eq("midrst_head", 32'(rx_rd[0]), idx);
      add_word(0, 9'h000);
      rx_wr[0]--;
      // Words from R3 onwards are a fresh frame start.
      begin
         logic [8:0] keep;
         keep = rx_mem[0][idx - 1];
         rx_mem[0][idx - 1] = 9'h000;
         model(0, 1'b1, idx - 1);
         rx_mem[0][idx - 1] = keep;
      end
      drain(1'b0);
      compare("midrst");

      // Randomized rounds on both channels.
      for (int r = 0; r < 20; r++) begin
         int start [NCH];
         bit en [NCH];
         if ($urandom_range(4) == 0) pulse_clr();
         for (int c = 0; c < NCH; c++) begin
            en[c]    = ($urandom_range(3) != 0);
            ch_en[c] = en[c];
            start[c] = rx_wr[c];
            for (int f = 0; f < $urandom_range(4, 1); f++) begin
               for (int k = 0; k < $urandom_range(2, 1); k++)
                  add_word(c, 9'($urandom_range(255)));
               for (int k = 0; k < $urandom_range(7, 1); k++)
                  add_word(c, {1'b1, 8'($urandom_range(255))});
            end
            add_word(c, 9'h000);
            model(c, en[c], start[c]);
         end
         drain(1'b1);
         compare("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/filter_fwd.md
# filter_fwd

Parametrised, frame-aware forwarding stage between PHY receive FIFOs and PHY transmit FIFOs. Each of `NCH` independent channels pops words from one receive FIFO and pushes them into one transmit FIFO. It discards idle words, admits or drops whole frames, truncates over-length frames, applies lossless backpressure, and keeps per-channel statistics. Port crossing (for example PHY0 rx to PHY1 tx) is done by wiring at instantiation.

## Interface
Parameters:
- `DATA_W`, default 8: payload width. Each FIFO word is `DATA_W+1` bits; bit `DATA_W` is the in-frame flag.
- `NCH`, default 2: number of channels.
- `MAX_LEN`, default 1518: maximum words per forwarded frame, including the start word; must be ≥1.
- `CNT_W`, default 16: width of each statistics counter.

Ports (buses are flattened; channel i occupies slice i):
- `sys_clk` input 1: the single clock.
- `sys_rst_n` input 1: reset, synchronous and active-low.
- `ch_en` input NCH: per-channel forwarding enable.
- `stat_clr` input 1: one-cycle pulse that clears all counters.
- `rd_en` output NCH: pop strobe to each receive FIFO.
- `rd_data` input NCH*(DATA_W+1): first-word-fall-through head word of each receive FIFO.
- `rd_empty` input NCH: receive FIFO empty.
- `wr_en` output NCH: push strobe to each transmit FIFO.
- `wr_data` output NCH*(DATA_W+1): word pushed to each transmit FIFO.
- `wr_full` input NCH: transmit FIFO full; no push is allowed while it is high.
- `fwd_cnt` output NCH*CNT_W: frames forwarded complete.
- `drop_cnt` output NCH*CNT_W: frames dropped whole.
- `trunc_cnt` output NCH*CNT_W: frames truncated.

## Operation
- Frame: a maximal run of words with flag=1. A flag=0 word is idle or a separator. An empty FIFO mid-frame does not end the frame.
- Each channel has its own FSM with states IDLE, FWD and DROP, plus a length counter `len` of width clog2(MAX_LEN+1).
- IDLE:
  - Head flag=0: pop, do not write.
  - Head flag=1 and `ch_en[i]`=1: wait while `wr_full`=1. Otherwise pop, write the word, set `len`=1, go to FWD.
  - Head flag=1 and `ch_en[i]`=0: pop, do not write, increment `drop_cnt`, go to DROP.
- FWD, head flag=1, `len`<MAX_LEN: when `wr_full`=0, pop, write the word, increment `len`. When `wr_full`=1, stall; nothing is lost.
- FWD, head flag=1, `len`=MAX_LEN: when `wr_full`=0, write the terminator {1'b0, 0}, do not pop, increment `trunc_cnt`, go to DROP.
- FWD, head flag=0: when `wr_full`=0, pop, write the terminator {1'b0, 0}, increment `fwd_cnt`, go to IDLE.
- DROP: pop flag=1 words without writing. A flag=0 word is popped without writing and the FSM goes to IDLE.
- `ch_en` is sampled only at the frame-start decision in IDLE. Deasserting it mid-frame does not affect the frame in progress.
- Counters saturate at all-ones.
- `stat_clr` zeroes every counter. If an increment and `stat_clr` occur in the same cycle, the counter reads 0.
- Channels are fully independent and share no arbitration.

## Timing
- `rd_en` and `wr_en` are combinational from the registered state, the `rd_*` inputs and `wr_full`.
- Zero latency: a word popped in cycle t is pushed in cycle t.
- At most one pop and one push per channel per cycle.
- `rd_en[i]` is never high while `rd_empty[i]`=1. `wr_en[i]` is never high while `wr_full[i]`=1.
- Throughput is one word per cycle when the receive FIFO is non-empty and the transmit FIFO is not full.
- Each frame costs one extra cycle for its terminator.
- Counters are registered and update in the cycle after the triggering event.
- While `sys_rst_n`=0: `rd_en`=0, `wr_en`=0, `wr_data`=0, all counters 0, every FSM in IDLE with `len`=0. Reset in mid-frame abandons the frame. The remaining words of that frame are then treated as new frame starts.
- `wr_data` is 0 whenever `wr_en`=0.

## Test plan
- Basic forward: ch0 receives idle, A1, A2, A3, idle with `wr_full`=0. Required: ch0 pushes A1, A2, A3 and {0,0} on four consecutive cycles; `fwd_cnt[0]`=1.
- Backpressure: hold `wr_full[0]`=1 for 5 cycles after A1. Required: `rd_en[0]`=0 during the stall; A2 is pushed the cycle `wr_full[0]` falls; no word is lost or duplicated.
- Disabled channel: `ch_en[1]`=0 and ch1 receives a 4-word frame. Required: no pushes; all 5 words popped; `drop_cnt[1]`=1. Re-enabling mid-frame still drops the rest of that frame.
- Truncation: `MAX_LEN`=4 and a 7-word frame arrives. Required: 4 words pushed then {0,0}; 3 words popped and discarded; `trunc_cnt`=1, `fwd_cnt`=0.
- Counters: `CNT_W`=2 and 5 frames forwarded. Required: `fwd_cnt`=3 (saturated). A `stat_clr` coinciding with a 6th frame gives 0.
- Reset mid-frame: assert `sys_rst_n`=0 after 2 of 4 words. Required: all outputs 0 on the next edge. After release, the 3rd word is forwarded as a new frame start.
